// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC with stall hold, branch redirect and multi-cycle
// wrong-path flush after each accepted redirect.
module pc_sequencer #(
  parameter int                ADDR_W      = 14,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                FLUSH_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] ins_br_addr,
  output logic [ADDR_W-1:0] ins_addr,
  output logic [ADDR_W-1:0] ins_inc_addr,
  output logic              fetch_valid,
  output logic              flush,
  output logic [15:0]       br_count
);
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
  state_t            r_state, w_state;
  logic [2:0]        r_cnt, w_cnt;
  logic [ADDR_W-1:0] r_addr, w_addr, w_inc, w_adv;
  logic              r_valid, r_flush, w_flush;
  logic [15:0]       r_count, w_count;
  assign w_inc        = r_addr + 1'b1;
  assign w_adv        = stall ? r_addr : w_inc;
  assign ins_addr     = r_addr;
  assign ins_inc_addr = w_inc;
  assign fetch_valid  = r_valid;
  assign flush        = r_flush;
  assign br_count     = r_count;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= BOOT;
      r_cnt   <= '0;
      r_addr  <= RESET_PC;
      r_valid <= 1'b0;
      r_flush <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_addr  <= w_addr;
      r_valid <= w_state != BOOT;
      r_flush <= w_flush;
      r_count <= w_count;
    end
  // Branches seen during FLUSH come from wrong-path instructions and are dropped.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_addr  = r_addr;
    w_flush = r_flush;
    w_count = r_count;
    case (r_state)
      BOOT: w_state = RUN;
      RUN:
        if (br_taken) begin
          w_addr  = ins_br_addr;
          w_state = FLUSH;
          w_cnt   = 3'(FLUSH_DEPTH - 1);
          w_flush = 1'b1;
          w_count = r_count + {15'd0, r_count != 16'hFFFF};
        end else
          w_addr = w_adv;
      FLUSH: begin
        w_addr = w_adv;
        if (r_cnt == 3'd0) begin
          w_state = RUN;
          w_flush = 1'b0;
        end else
          w_cnt = r_cnt - 1'b1;
      end
      default: w_state = BOOT;
    endcase
  end
endmodule
